// File: rtl/uart_pkg.sv
// Shared types and constants for the oversampling UART receiver.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;

  // Sample-counter values at which the start bit and the data/stop bits are examined.
  localparam logic [3:0] MID_SAMPLE  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] LAST_SAMPLE = 4'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_e;

  function automatic int calc_div(input int clock_freq, input int baud_rate);
    return clock_freq / (baud_rate * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every DIV clocks while enabled.
module uart_baud_tick #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int               CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = enable && (cnt_q == CNT_LAST);

  // Holding the count at zero while disabled aligns tick phase to start detection.
  always_comb begin
    cnt_d = cnt_q;
    if (!enable || tick) cnt_d = '0;
    else                 cnt_d = cnt_q + CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_oversample.sv
// 16x-oversampling 8N1 UART receiver with glitch rejection, framing-error
// detection and a ready/ack output holding register with overrun detection.
module uart_rx_oversample
  import uart_pkg::*;
#(
  parameter int clock_freq = 50000000,
  parameter int baud_rate  = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       data_ack,
  output logic [7:0] received_data,
  output logic       data_ready,
  output logic       frame_error,
  output logic       overrun,
  output logic       rx_busy
);

  localparam int DIV = calc_div(clock_freq, baud_rate);

  logic            sync1_q, rx_s;
  rx_state_e       state_q, state_d;
  logic [3:0]      sample_cnt_q, sample_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            ready_q, ready_d;
  logic            fe_q, fe_d;
  logic            ov_q, ov_d;
  logic            load;
  logic            tick;

  uart_baud_tick #(.DIV(DIV)) u_baud_tick (
    .clk    (clk),
    .rst    (rst),
    .enable (state_q != IDLE),
    .tick   (tick)
  );

  // NOTE: the async reset lives in the sensitivity list; resetting to idle-high keeps a reset from looking like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      sync1_q <= rx;
      rx_s    <= sync1_q;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    load         = 1'b0;
    fe_d         = 1'b0;

    unique case (state_q)
      IDLE: begin
        sample_cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (tick) begin
          if (sample_cnt_q == MID_SAMPLE) begin
            sample_cnt_d = '0;
            bit_idx_d    = '0;
            state_d      = rx_s ? IDLE : DATA;
          end else begin
            sample_cnt_d = sample_cnt_q + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          sample_cnt_d = sample_cnt_q + 4'd1;
          if (sample_cnt_q == LAST_SAMPLE) begin
            shift_d = {rx_s, shift_q[7:1]};
            if (bit_idx_q == 3'(DATA_BITS - 1)) state_d   = STOP;
            else                                bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          sample_cnt_d = sample_cnt_q + 4'd1;
          if (sample_cnt_q == LAST_SAMPLE) begin
            if (rx_s) begin
              load    = 1'b1;
              state_d = IDLE;
            end else begin
              fe_d    = 1'b1;
              state_d = BREAK;
            end
          end
        end
      end
      BREAK: begin
        // A held-low line parks here so it reports only one framing error.
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A load beats a simultaneous ack; overrun only when the old byte was never taken.
  always_comb begin
    data_d  = data_q;
    ready_d = ready_q;
    ov_d    = 1'b0;
    if (load) begin
      data_d  = shift_q;
      ready_d = 1'b1;
      ov_d    = ready_q && !data_ack;
    end else if (data_ack) begin
      ready_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      sample_cnt_q <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      ready_q      <= 1'b0;
      fe_q         <= 1'b0;
      ov_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      sample_cnt_q <= sample_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      ready_q      <= ready_d;
      fe_q         <= fe_d;
      ov_q         <= ov_d;
    end
  end

  assign received_data = data_q;
  assign data_ready    = ready_q;
  assign frame_error   = fe_q;
  assign overrun       = ov_q;
  assign rx_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Directed bench for uart_rx_oversample: a fast DIV=1 instance plus a default-rate instance.
module tb_uart_rx_oversample;

  localparam int BIT_FAST = 16;
  localparam int BIT_SLOW = 16 * 325;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx, rx2;
  logic       data_ack, data_ack2;
  logic [7:0] received_data, received_data2;
  logic       data_ready, data_ready2;
  logic       frame_error, frame_error2;
  logic       overrun, overrun2;
  logic       rx_busy, rx_busy2;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];

  int unsigned cyc = 0;
  int unsigned rise_cyc = 0, rise_cyc2 = 0;
  int          rise_cnt = 0, rise_cnt2 = 0;
  int          fe_cnt = 0, ov_cnt = 0;
  logic        ready_prev = 1'b0, ready_prev2 = 1'b0;

  always #5 clk = ~clk;

  uart_rx_oversample #(.clock_freq(1600000), .baud_rate(100000)) dut (
    .clk           (clk),
    .rst           (rst),
    .rx            (rx),
    .data_ack      (data_ack),
    .received_data (received_data),
    .data_ready    (data_ready),
    .frame_error   (frame_error),
    .overrun       (overrun),
    .rx_busy       (rx_busy)
  );

  uart_rx_oversample dut_slow (
    .clk           (clk),
    .rst           (rst),
    .rx            (rx2),
    .data_ack      (data_ack2),
    .received_data (received_data2),
    .data_ready    (data_ready2),
    .frame_error   (frame_error2),
    .overrun       (overrun2),
    .rx_busy       (rx_busy2)
  );

  // Event monitor: counts pulses and timestamps data_ready rises.
  always @(posedge clk) begin
    cyc         <= cyc + 1;
    ready_prev  <= data_ready;
    ready_prev2 <= data_ready2;
    if (frame_error) fe_cnt <= fe_cnt + 1;
    if (overrun)     ov_cnt <= ov_cnt + 1;
    if (data_ready && !ready_prev) begin
      rise_cnt <= rise_cnt + 1;
      rise_cyc <= cyc;
    end
    if (data_ready2 && !ready_prev2) begin
      rise_cnt2 <= rise_cnt2 + 1;
      rise_cyc2 <= cyc;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag, input logic [7:0] obs);
    logic [8:0] e;
    e = (exp_q.size() != 0) ? {1'b1, exp_q.pop_front()} : 9'h000;
    check(tag, {1'b1, obs}, e);
  endtask

  task automatic drive_line(input bit sel, input logic v);
    if (sel) rx2 = v;
    else     rx  = v;
  endtask

  // Called at a negedge; returns at the negedge ending the stop bit.
  task automatic send_frame(input bit sel, input logic [7:0] b, input logic stop, input int bit_cyc);
    drive_line(sel, 1'b0);
    repeat (bit_cyc) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      drive_line(sel, b[i]);
      repeat (bit_cyc) @(negedge clk);
    end
    drive_line(sel, stop);
    repeat (bit_cyc) @(negedge clk);
  endtask

  task automatic ack_pulse();
    data_ack = 1'b1;
    @(negedge clk);
    data_ack = 1'b0;
  endtask

  initial begin
    int unsigned c0;
    int          base;

    rst = 1'b1; rx = 1'b1; rx2 = 1'b1; data_ack = 1'b0; data_ack2 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data",    {24'd0, received_data}, 32'h00);
    check("rst_ready",   data_ready,  1'b0);
    check("rst_ferr",    frame_error, 1'b0);
    check("rst_overrun", overrun,     1'b0);
    check("rst_busy",    rx_busy,     1'b0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Good frame with exact latency
    c0 = cyc;
    base = fe_cnt;
    exp_q.push_back(8'hA5);
    send_frame(1'b0, 8'hA5, 1'b1, BIT_FAST);
    check("a5_latency", rise_cyc - c0, 155);
    check("a5_ready",   data_ready, 1'b1);
    sb_check("a5_data", received_data);
    check("a5_no_ferr", fe_cnt - base, 0);
    ack_pulse();
    check("a5_ack_clears", data_ready, 1'b0);
    ack_pulse();
    check("idle_ack_ignored", data_ready, 1'b0);

    // Glitch start
    base = rise_cnt;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    check("glitch_busy", rx_busy, 1'b1);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_idle",     rx_busy, 1'b0);
    check("glitch_no_ready", data_ready, 1'b0);
    check("glitch_no_rise",  rise_cnt - base, 0);

    // Framing error, then held-low break
    base = fe_cnt;
    send_frame(1'b0, 8'h3C, 1'b0, BIT_FAST);
    repeat (40) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    check("ferr_one_pulse", fe_cnt - base, 1);
    check("ferr_data_kept", {24'd0, received_data}, 32'hA5);
    check("ferr_no_ready",  data_ready, 1'b0);
    check("ferr_idle",      rx_busy, 1'b0);
    exp_q.push_back(8'h55);
    send_frame(1'b0, 8'h55, 1'b1, BIT_FAST);
    check("f55_ready", data_ready, 1'b1);
    sb_check("f55_data", received_data);
    ack_pulse();

    // Overrun, then load coincident with ack
    base = ov_cnt;
    exp_q.push_back(8'h11);
    send_frame(1'b0, 8'h11, 1'b1, BIT_FAST);
    sb_check("f11_data", received_data);
    exp_q.push_back(8'h22);
    send_frame(1'b0, 8'h22, 1'b1, BIT_FAST);
    check("ovr_pulse_once", ov_cnt - base, 1);
    check("ovr_ready",      data_ready, 1'b1);
    sb_check("ovr_data", received_data);
    exp_q.push_back(8'h33);
    fork
      send_frame(1'b0, 8'h33, 1'b1, BIT_FAST);
      begin
        repeat (154) @(negedge clk);
        ack_pulse();
      end
    join
    check("ackload_no_ovr", ov_cnt - base, 1);
    check("ackload_ready",  data_ready, 1'b1);
    sb_check("ackload_data", received_data);

    // Reset during data bit 4 of 0xFF
    rx = 1'b0;
    repeat (BIT_FAST) @(negedge clk);
    rx = 1'b1;
    repeat (4 * BIT_FAST + 8) @(negedge clk);
    check("pre_rst_busy", rx_busy, 1'b1);
    rst = 1'b1;
    #1;
    check("midrst_data",  {24'd0, received_data}, 32'h00);
    check("midrst_ready", data_ready, 1'b0);
    check("midrst_busy",  rx_busy, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    exp_q.push_back(8'h81);
    send_frame(1'b0, 8'h81, 1'b1, BIT_FAST);
    check("f81_ready", data_ready, 1'b1);
    sb_check("f81_data", received_data);
    ack_pulse();

    // Back-to-back frames with ack after each
    base = rise_cnt;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h5A);
    fork
      begin
        send_frame(1'b0, 8'h00, 1'b1, BIT_FAST);
        send_frame(1'b0, 8'hFF, 1'b1, BIT_FAST);
        send_frame(1'b0, 8'h5A, 1'b1, BIT_FAST);
      end
      begin
        for (int f = 0; f < 3; f++) begin
          int  r;
          bit  seen;
          r = rise_cnt;
          seen = 1'b0;
          for (int k = 0; k < 400 && !seen; k++) begin
            @(negedge clk);
            if (rise_cnt != r) seen = 1'b1;
          end
          check("b2b_rise_seen", seen, 1'b1);
          sb_check("b2b_data", received_data);
          ack_pulse();
        end
      end
    join
    check("b2b_rise_count", rise_cnt - base, 3);

    // Default parameters (DIV=325)
    c0 = cyc;
    exp_q.push_back(8'hC3);
    send_frame(1'b1, 8'hC3, 1'b1, BIT_SLOW);
    check("slow_latency", rise_cyc2 - c0, 3 + 152 * 325);
    check("slow_rises",   rise_cnt2, 1);
    check("slow_ready",   data_ready2, 1'b1);
    sb_check("slow_data", received_data2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
